// File: rtl/pipe_pkg.sv
// Shared types and field layout for the ready/valid pipeline stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // EX/MEM control bundle layout (7 bits)
    localparam int unsigned REG_WRITE_BIT = 6;
    localparam int unsigned RW_LSB        = 2;
    localparam int unsigned RW_W          = 4;
    localparam int unsigned WBSEL_LSB     = 0;
    localparam int unsigned WBSEL_W       = 2;

    // EX/MEM data bundle layout (5 x 32 bits)
    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEST_LSB = 128;
    localparam int unsigned PC_LSB   = 96;
    localparam int unsigned ALU_LSB  = 64;
    localparam int unsigned RS2_LSB  = 32;
    localparam int unsigned IMM_LSB  = 0;

    typedef struct packed {
        logic              reg_write;
        logic [RW_W-1:0]   read_write;
        logic [WBSEL_W-1:0] wb_sel;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] dest;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
    } ex_mem_data_t;

    function automatic logic [1:0] occ_of(input state_e s);
        case (s)
            ST_ONE:  occ_of = 2'd1;
            ST_TWO:  occ_of = 2'd2;
            default: occ_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter; holds at all-ones, cleared only by reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Ready/valid pipeline stage with optional 2-entry skid, flush-to-bubble and stall counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W     = 160,
    parameter int unsigned CTRL_W     = 7,
    parameter int unsigned SKID       = 1,
    parameter int unsigned CLEAR_DATA = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              out_valid_q, out_valid_d;
    logic [1:0]        occupancy_q, occupancy_d;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid_q & out_ready;

    // Next-state and storage steering; flush overrides everything, bubbles carry zero ctrl
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d     = ST_ONE;
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                end else if (in_fire && (SKID != 0)) begin
                    state_d     = ST_TWO;
                    skid_ctrl_d = in_ctrl;
                    skid_data_d = in_data;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    state_d     = ST_ONE;
                    main_ctrl_d = skid_ctrl_q;
                    main_data_d = skid_data_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (flush) begin
            state_d = ST_EMPTY;
        end

        if (state_d == ST_EMPTY) begin
            main_ctrl_d = '0;
            if (CLEAR_DATA != 0) begin
                main_data_d = '0;
            end
        end
        if (state_d != ST_TWO) begin
            skid_ctrl_d = '0;
        end

        out_valid_d = (state_d != ST_EMPTY);
        occupancy_d = occ_of(state_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            out_valid_q <= 1'b0;
            occupancy_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            out_valid_q <= out_valid_d;
            occupancy_q <= occupancy_d;
        end
    end

    // Skid build registers in_ready to break the out_ready->in_ready path
    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q, in_ready_d;

            always_comb begin
                in_ready_d = (state_d != ST_TWO);
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= in_ready_d;
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign in_ready = ~out_valid_q | out_ready;
        end
    endgenerate

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid_q & ~out_ready),
        .count (stall_cnt)
    );

    assign out_valid = out_valid_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign occupancy = occupancy_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: default skid build, CNT_W=3 build and SKID=0 build on shared stimulus.
module tb_pipe_stage_skid;

    localparam int unsigned DW = 160;
    localparam int unsigned CW = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          a_in_ready, a_out_valid;
    logic [CW-1:0] a_out_ctrl;
    logic [DW-1:0] a_out_data;
    logic [1:0]    a_occ;
    logic [15:0]   a_stall;

    logic          c_in_ready, c_out_valid;
    logic [CW-1:0] c_out_ctrl;
    logic [DW-1:0] c_out_data;
    logic [1:0]    c_occ;
    logic [2:0]    c_stall;

    logic          z_in_ready, z_out_valid;
    logic [CW-1:0] z_out_ctrl;
    logic [DW-1:0] z_out_data;
    logic [1:0]    z_occ;
    logic [15:0]   z_stall;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] data_a, data_b, data_c, data_d, data_e, data_x, data_y;

    always #5 clk = ~clk;

    pipe_stage_skid u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
        .occupancy(a_occ), .stall_cnt(a_stall)
    );

    pipe_stage_skid #(.CNT_W(3)) u_cnt3 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(c_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_ctrl(c_out_ctrl), .out_data(c_out_data),
        .occupancy(c_occ), .stall_cnt(c_stall)
    );

    pipe_stage_skid #(.SKID(0)) u_noskid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(z_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(z_out_valid), .out_ready(out_ready), .out_ctrl(z_out_ctrl), .out_data(z_out_data),
        .occupancy(z_occ), .stall_cnt(z_stall)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // The single-entry build must never report more than one entry
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            assert (z_occ <= 2'd1) else begin
                errors++;
                $error("FAIL noskid_occ_max observed=%0d expected<=1", z_occ);
            end
        end
    end

    initial begin
        data_a = 160'h11111111_22222222_33333333_44444444_55555555;
        data_b = 160'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD_EEEEEEEE;
        data_c = 160'hC0C0C0C0_00000000_00000000_00000000_0000C0C0;
        data_d = 160'hD0D0D0D0_00000000_00000000_00000000_0000D0D0;
        data_e = 160'hE0E0E0E0_00000000_00000000_00000000_0000E0E0;
        data_x = 160'h12345678_9ABCDEF0_0FEDCBA9_87654321_DEADBEEF;
        data_y = 160'h0BADF00D_CAFEBABE_FEEDFACE_01234567_89ABCDEF;

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_ctrl   = '0;
        in_data   = '0;
        step();
        step();

        // Reset values
        check("rst_out_valid", DW'(a_out_valid), DW'(0));
        check("rst_out_ctrl",  DW'(a_out_ctrl),  DW'(0));
        check("rst_out_data",  a_out_data,        DW'(0));
        check("rst_occ",       DW'(a_occ),        DW'(0));
        check("rst_in_ready",  DW'(a_in_ready),   DW'(1));
        check("rst_stall",     DW'(a_stall),      DW'(0));
        check("rst_noskid_in_ready", DW'(z_in_ready), DW'(1));
        reset = 1'b0;

        // Streaming 1..8, one-cycle latency, no gaps
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            in_ctrl  = CW'(i);
            step();
            check($sformatf("stream_valid_%0d", i), DW'(a_out_valid), DW'(1));
            check($sformatf("stream_data_%0d", i),  a_out_data,        DW'(i));
            check($sformatf("stream_ctrl_%0d", i),  DW'(a_out_ctrl),  DW'(i));
            check($sformatf("stream_in_ready_%0d", i), DW'(a_in_ready), DW'(1));
        end
        in_valid = 1'b0;
        step();
        check("stream_drain_valid", DW'(a_out_valid), DW'(0));
        check("stream_drain_ctrl",  DW'(a_out_ctrl),  DW'(0));
        check("stream_drain_data_held", a_out_data,   DW'(8));
        check("stream_drain_occ",   DW'(a_occ),       DW'(0));
        check("stream_stall",       DW'(a_stall),     DW'(0));

        // Backpressure: A then B with downstream stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = data_a;
        in_ctrl   = 7'h55;
        step();
        check("bp_a_occ",      DW'(a_occ),      DW'(1));
        check("bp_a_in_ready", DW'(a_in_ready), DW'(1));
        in_data = data_b;
        in_ctrl = 7'h2A;
        step();
        check("bp_two_occ",      DW'(a_occ),      DW'(2));
        check("bp_two_in_ready", DW'(a_in_ready), DW'(0));
        check("bp_two_data",     a_out_data,       data_a);
        check("bp_two_ctrl",     DW'(a_out_ctrl), DW'(7'h55));
        check("bp_noskid_in_ready", DW'(z_in_ready), DW'(0));
        check("bp_noskid_occ",      DW'(z_occ),      DW'(1));
        check("bp_noskid_data",     z_out_data,       data_a);
        in_valid = 1'b0;
        step();
        check("bp_hold_data",  a_out_data,   data_a);
        check("bp_hold_occ",   DW'(a_occ),   DW'(2));
        check("bp_hold_stall", DW'(a_stall), DW'(2));
        out_ready = 1'b1;
        #1;
        check("bp_noskid_comb_ready", DW'(z_in_ready), DW'(1));
        check("bp_skid_reg_ready",    DW'(a_in_ready), DW'(0));
        step();
        check("bp_pop_a_data",     a_out_data,        data_b);
        check("bp_pop_a_ctrl",     DW'(a_out_ctrl),  DW'(7'h2A));
        check("bp_pop_a_occ",      DW'(a_occ),       DW'(1));
        check("bp_pop_a_in_ready", DW'(a_in_ready),  DW'(1));
        check("bp_pop_a_stall",    DW'(a_stall),     DW'(2));
        step();
        check("bp_pop_b_valid", DW'(a_out_valid), DW'(0));
        check("bp_pop_b_ctrl",  DW'(a_out_ctrl),  DW'(0));
        check("bp_pop_b_occ",   DW'(a_occ),       DW'(0));

        // Flush in TWO with an offered entry, then flush in ONE with a real in_fire
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = data_a;
        in_ctrl   = 7'h11;
        step();
        in_data = data_b;
        in_ctrl = 7'h22;
        step();
        check("fl_pre_occ", DW'(a_occ), DW'(2));
        flush   = 1'b1;
        in_data = data_c;
        in_ctrl = 7'h33;
        step();
        check("fl_two_occ",      DW'(a_occ),       DW'(0));
        check("fl_two_valid",    DW'(a_out_valid), DW'(0));
        check("fl_two_ctrl",     DW'(a_out_ctrl),  DW'(0));
        check("fl_two_data_held", a_out_data,       data_a);
        check("fl_two_in_ready", DW'(a_in_ready),  DW'(1));
        flush   = 1'b0;
        in_data = data_d;
        in_ctrl = 7'h44;
        step();
        check("fl_one_pre_occ", DW'(a_occ), DW'(1));
        flush   = 1'b1;
        in_data = data_e;
        in_ctrl = 7'h66;
        step();
        check("fl_one_valid", DW'(a_out_valid), DW'(0));
        check("fl_one_ctrl",  DW'(a_out_ctrl),  DW'(0));
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        check("fl_dropped_valid", DW'(a_out_valid), DW'(0));
        check("fl_dropped_occ",   DW'(a_occ),       DW'(0));
        check("fl_stall",         DW'(a_stall),     DW'(5));
        check("fl_stall_cnt3",    DW'(c_stall),     DW'(5));
        check("fl_noskid_occ",    DW'(z_occ),       DW'(0));

        // Saturation of the 3-bit stall counter
        in_valid = 1'b1;
        in_data  = data_x;
        in_ctrl  = 7'h77;
        step();
        in_valid = 1'b0;
        step();
        check("sat_cnt3_6", DW'(c_stall), DW'(6));
        step();
        check("sat_cnt3_7", DW'(c_stall), DW'(7));
        for (int i = 0; i < 10; i++) begin
            step();
        end
        check("sat_cnt3_hold", DW'(c_stall), DW'(7));
        check("sat_cnt16",     DW'(a_stall), DW'(17));
        check("sat_data_held", a_out_data,    data_x);

        // Asynchronous reset from TWO
        in_valid = 1'b1;
        in_data  = data_y;
        in_ctrl  = 7'h0F;
        step();
        check("arst_pre_occ", DW'(a_occ), DW'(2));
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check("arst_valid",    DW'(a_out_valid), DW'(0));
        check("arst_ctrl",     DW'(a_out_ctrl),  DW'(0));
        check("arst_occ",      DW'(a_occ),       DW'(0));
        check("arst_in_ready", DW'(a_in_ready),  DW'(1));
        check("arst_stall",    DW'(a_stall),     DW'(0));
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        step();
        check("post_rst_valid", DW'(a_out_valid), DW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
